// File: rtl/binary_bbox.sv
// Bounding box of all-zero (foreground) pixels per frame, latched on each vsync
// rising edge, with the previous frame's box drawn back onto the video stream.
module binary_bbox #(
  parameter int              DW        = 24,
  parameter int              XW        = 12,
  parameter int              YW        = 12,
  parameter int              MIN_CNT   = 64,
  parameter logic [DW-1:0]   BOX_COLOR = 24'hFF0000
) (
  input  logic             pixelclk,
  input  logic             reset_n,
  input  logic [DW-1:0]    i_binary,
  input  logic             i_hsync,
  input  logic             i_vsync,
  input  logic             i_de,
  output logic [DW-1:0]    o_data,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_de,
  output logic [XW-1:0]    o_x_min,
  output logic [XW-1:0]    o_x_max,
  output logic [YW-1:0]    o_y_min,
  output logic [YW-1:0]    o_y_max,
  output logic [XW+YW-1:0] o_fg_count,
  output logic             o_box_valid,
  output logic             o_frame_done
);

  // state  | meaning
  // IDLE   | waiting for the first vsync edge after reset; nothing accumulated
  // ACTIVE | accumulating foreground pixels, latching results on every vsync edge

  localparam int CW = XW + YW;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t         state, state_next;
  logic           acc_en, latch_en;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [XW-1:0]  acc_x_min, acc_x_max;
  logic [YW-1:0]  acc_y_min, acc_y_max;
  logic [CW-1:0]  acc_cnt;
  logic           vs_rise, de_fall, is_fg, on_col, on_row, overlay;

  // o_vsync / o_de double as the registered copies used for edge detection
  assign vs_rise = i_vsync & ~o_vsync;
  assign de_fall = o_de & ~i_de;
  assign is_fg   = (i_binary == '0);

  assign on_col  = ((x == o_x_min) || (x == o_x_max)) && (y >= o_y_min) && (y <= o_y_max);
  assign on_row  = ((y == o_y_min) || (y == o_y_max)) && (x >= o_x_min) && (x <= o_x_max);
  assign overlay = o_box_valid && i_de && (on_col || on_row);

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    acc_en     = 1'b0;
    latch_en   = 1'b0;
    case (state)
      IDLE: begin
        if (vs_rise) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (vs_rise) latch_en = 1'b1;
        else         acc_en   = i_de && is_fg;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (vs_rise) begin
      x <= '0;
      y <= '0;
    end else if (de_fall) begin
      x <= '0;
      if (y != '1) y <= y + YW'(1);
    end else if (i_de && (x != '1)) begin
      x <= x + XW'(1);
    end
  end

  // a foreground pixel on the vsync-edge cycle is dropped by the reinit branch
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      acc_x_min <= '1;
      acc_x_max <= '0;
      acc_y_min <= '1;
      acc_y_max <= '0;
      acc_cnt   <= '0;
    end else if (vs_rise) begin
      acc_x_min <= '1;
      acc_x_max <= '0;
      acc_y_min <= '1;
      acc_y_max <= '0;
      acc_cnt   <= '0;
    end else if (acc_en) begin
      if (x < acc_x_min) acc_x_min <= x;
      if (x > acc_x_max) acc_x_max <= x;
      if (y < acc_y_min) acc_y_min <= y;
      if (y > acc_y_max) acc_y_max <= y;
      if (acc_cnt != '1) acc_cnt <= acc_cnt + CW'(1);
    end
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      o_x_min      <= '0;
      o_x_max      <= '0;
      o_y_min      <= '0;
      o_y_max      <= '0;
      o_fg_count   <= '0;
      o_box_valid  <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= latch_en;
      if (latch_en) begin
        o_fg_count <= acc_cnt;
        if (acc_cnt >= CW'(MIN_CNT)) begin
          o_x_min     <= acc_x_min;
          o_x_max     <= acc_x_max;
          o_y_min     <= acc_y_min;
          o_y_max     <= acc_y_max;
          o_box_valid <= 1'b1;
        end else begin
          o_x_min     <= '0;
          o_x_max     <= '0;
          o_y_min     <= '0;
          o_y_max     <= '0;
          o_box_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      o_data  <= '0;
      o_hsync <= 1'b0;
      o_vsync <= 1'b0;
      o_de    <= 1'b0;
    end else begin
      o_data  <= overlay ? BOX_COLOR : i_binary;
      o_hsync <= i_hsync;
      o_vsync <= i_vsync;
      o_de    <= i_de;
    end
  end

endmodule

// File: tb/tb_binary_bbox.sv
// Directed bench for binary_bbox on an 8x4 frame: a frame-level model computes
// boxes from the list of foreground pixels and is compared every cycle.
module tb_binary_bbox;

  localparam int          DW      = 24;
  localparam int          XW      = 12;
  localparam int          YW      = 12;
  localparam int          MIN_CNT = 4;
  localparam logic [23:0] BOX     = 24'hFF0000;

  logic             pixelclk;
  logic             reset_n;
  logic [DW-1:0]    i_binary;
  logic             i_hsync, i_vsync, i_de;
  logic [DW-1:0]    o_data;
  logic             o_hsync, o_vsync, o_de;
  logic [XW-1:0]    o_x_min, o_x_max;
  logic [YW-1:0]    o_y_min, o_y_max;
  logic [XW+YW-1:0] o_fg_count;
  logic             o_box_valid, o_frame_done;

  binary_bbox #(.DW(DW), .XW(XW), .YW(YW), .MIN_CNT(MIN_CNT), .BOX_COLOR(BOX)) dut (
    .pixelclk(pixelclk), .reset_n(reset_n), .i_binary(i_binary), .i_hsync(i_hsync),
    .i_vsync(i_vsync), .i_de(i_de), .o_data(o_data), .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_de(o_de), .o_x_min(o_x_min), .o_x_max(o_x_max), .o_y_min(o_y_min), .o_y_max(o_y_max),
    .o_fg_count(o_fg_count), .o_box_valid(o_box_valid), .o_frame_done(o_frame_done)
  );

  initial pixelclk = 1'b0;
  always #5 pixelclk = ~pixelclk;

  int checks = 0;
  int errors = 0;

  // model state: expected outputs plus the frame's foreground pixel list
  int e_data, e_hs, e_vs, e_de, e_xmin, e_xmax, e_ymin, e_ymax, e_cnt, e_valid, e_done;
  int m_active, m_vs_prev;
  int qx[$], qy[$];
  bit chk_en;
  bit fg[0:3][0:7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge pixelclk) begin
    #1;
    if (chk_en) begin
      chk("o_data",       32'(o_data),       e_data);
      chk("o_hsync",      32'(o_hsync),      e_hs);
      chk("o_vsync",      32'(o_vsync),      e_vs);
      chk("o_de",         32'(o_de),         e_de);
      chk("o_x_min",      32'(o_x_min),      e_xmin);
      chk("o_x_max",      32'(o_x_max),      e_xmax);
      chk("o_y_min",      32'(o_y_min),      e_ymin);
      chk("o_y_max",      32'(o_y_max),      e_ymax);
      chk("o_fg_count",   32'(o_fg_count),   e_cnt);
      chk("o_box_valid",  32'(o_box_valid),  e_valid);
      chk("o_frame_done", 32'(o_frame_done), e_done);
    end
  end

  task automatic model_reset();
    {e_data, e_hs, e_vs, e_de, e_xmin, e_xmax, e_ymin, e_ymax} = '0;
    {e_cnt, e_valid, e_done, m_active, m_vs_prev} = '0;
    qx.delete();
    qy.delete();
  endtask

  function automatic logic [23:0] bgval(input int c, input int r);
    return 24'h110000 | 24'(r * 16 + c);
  endfunction

  // drive one pixel (px,py is where the bench placed it), update model, step a clock
  task automatic cycle(input logic [23:0] b, input logic hs, input logic vs, input logic de,
                       input int px, input int py);
    bit on;
    int xmn, xmx, ymn, ymx;
    i_binary = b; i_hsync = hs; i_vsync = vs; i_de = de;
    on = (e_valid != 0) && de &&
         ((((px == e_xmin) || (px == e_xmax)) && (py >= e_ymin) && (py <= e_ymax)) ||
          (((py == e_ymin) || (py == e_ymax)) && (px >= e_xmin) && (px <= e_xmax)));
    e_data = on ? 32'(BOX) : 32'(b);
    e_hs = 32'(hs); e_vs = 32'(vs); e_de = 32'(de);
    e_done = 0;
    if (vs && m_vs_prev == 0) begin
      if (m_active != 0) begin
        e_done = 1;
        e_cnt  = qx.size();
        if (qx.size() >= MIN_CNT) begin
          xmn = 32'hFFF; xmx = 0; ymn = 32'hFFF; ymx = 0;
          for (int i = 0; i < qx.size(); i++) begin
            if (qx[i] < xmn) xmn = qx[i];
            if (qx[i] > xmx) xmx = qx[i];
            if (qy[i] < ymn) ymn = qy[i];
            if (qy[i] > ymx) ymx = qy[i];
          end
          e_xmin = xmn; e_xmax = xmx; e_ymin = ymn; e_ymax = ymx; e_valid = 1;
        end else begin
          e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; e_valid = 0;
        end
      end
      m_active = 1;
      qx.delete();
      qy.delete();
    end else if (m_active != 0 && de && b == '0) begin
      qx.push_back(px);
      qy.push_back(py);
    end
    m_vs_prev = 32'(vs);
    @(posedge pixelclk);
    #2;
  endtask

  task automatic clear_fg();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) fg[r][c] = 1'b0;
  endtask

  task automatic run_frame(input int y0, input bit lit);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        cycle(fg[r][c] ? 24'h0 : bgval(c, r), 1'b0, 1'b0, 1'b1, c, r + y0);
        if (lit) begin
          if ((c == 2 && r + y0 == 1) || (c == 5 && r + y0 == 3) || (c == 4 && r + y0 == 3))
            chk("overlay_edge", 32'(o_data), 32'(BOX));
          if (c == 3 && r + y0 == 2)
            chk("overlay_inside", 32'(o_data), 32'(bgval(3, 2)));
        end
      end
      cycle(bgval(0, 9), 1'b1, 1'b0, 1'b0, 0, 0);
      cycle(bgval(0, 9), 1'b1, 1'b0, 1'b0, 0, 0);
    end
  endtask

  task automatic vsync_edge(input bit fg_on_edge);
    cycle(fg_on_edge ? 24'h0 : bgval(1, 9), 1'b0, 1'b1, fg_on_edge, 0, 4);
  endtask

  task automatic vsync_tail();
    cycle(bgval(2, 9), 1'b0, 1'b1, 1'b0, 0, 0);
    chk("done_one_cycle", 32'(o_frame_done), 0);
    cycle(bgval(2, 9), 1'b0, 1'b1, 1'b0, 0, 0);
    cycle(bgval(2, 9), 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic chk_box(input string tag, input int xmn, input int xmx, input int ymn,
                         input int ymx, input int cnt, input int vld);
    chk({tag, "_xmin"},  32'(o_x_min),      xmn);
    chk({tag, "_xmax"},  32'(o_x_max),      xmx);
    chk({tag, "_ymin"},  32'(o_y_min),      ymn);
    chk({tag, "_ymax"},  32'(o_y_max),      ymx);
    chk({tag, "_cnt"},   32'(o_fg_count),   cnt);
    chk({tag, "_valid"}, 32'(o_box_valid),  vld);
    chk({tag, "_done"},  32'(o_frame_done), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},  32'(o_data),       0);
    chk({tag, "_de"},    32'(o_de),         0);
    chk({tag, "_hs"},    32'(o_hsync),      0);
    chk({tag, "_vs"},    32'(o_vsync),      0);
    chk({tag, "_xmax"},  32'(o_x_max),      0);
    chk({tag, "_ymax"},  32'(o_y_max),      0);
    chk({tag, "_cnt"},   32'(o_fg_count),   0);
    chk({tag, "_valid"}, 32'(o_box_valid),  0);
    chk({tag, "_done"},  32'(o_frame_done), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    i_binary = '0; i_hsync = 1'b0; i_vsync = 1'b0; i_de = 1'b0;
    chk_en = 1'b0;
    model_reset();
    clear_fg();
    repeat (3) @(posedge pixelclk);
    #1;
    chk_all_zero("reset");
    @(negedge pixelclk);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    cycle(bgval(0, 8), 1'b0, 1'b0, 1'b0, 0, 0);
    cycle(bgval(0, 8), 1'b0, 1'b0, 1'b0, 0, 0);

    vsync_edge(1'b0);
    chk("first_edge_no_done", 32'(o_frame_done), 0);
    vsync_tail();

    // valid box x 2..5, y 1..3
    for (int r = 1; r <= 3; r++)
      for (int c = 2; c <= 5; c++) fg[r][c] = 1'b1;
    run_frame(0, 1'b0);
    vsync_edge(1'b0);
    chk_box("boxA", 2, 5, 1, 3, 12, 1);
    vsync_tail();

    // all background; overlay of the previous box
    clear_fg();
    run_frame(0, 1'b1);
    vsync_edge(1'b0);
    chk_box("empty", 0, 0, 0, 0, 0, 0);
    vsync_tail();

    // three foreground pixels, below MIN_CNT
    fg[0][1] = 1'b1; fg[3][7] = 1'b1; fg[2][4] = 1'b1;
    run_frame(0, 1'b0);
    vsync_edge(1'b0);
    chk_box("three", 0, 0, 0, 0, 3, 0);
    vsync_tail();

    // four pixels, then a foreground pixel on the vsync edge itself
    clear_fg();
    for (int c = 1; c <= 4; c++) fg[2][c] = 1'b1;
    run_frame(0, 1'b0);
    vsync_edge(1'b1);
    chk_box("edgeD", 1, 4, 2, 2, 4, 1);
    vsync_tail();

    // de fell right after the edge cycle, so this frame's rows start at y=1
    clear_fg();
    fg[1][6] = 1'b1; fg[1][7] = 1'b1; fg[2][6] = 1'b1; fg[2][7] = 1'b1;
    run_frame(1, 1'b0);
    vsync_edge(1'b0);
    chk_box("edgeE", 6, 7, 2, 3, 4, 1);
    vsync_tail();

    // reset in the middle of a line
    for (int c = 0; c < 8; c++) cycle(24'h0, 1'b0, 1'b0, 1'b1, c, 0);
    reset_n = 1'b0;
    chk_en  = 1'b0;
    #1;
    chk_all_zero("midreset");
    model_reset();
    i_binary = '0; i_hsync = 1'b0; i_vsync = 1'b0; i_de = 1'b0;
    repeat (2) @(posedge pixelclk);
    @(negedge pixelclk);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    for (int c = 0; c < 8; c++) cycle(24'h0, 1'b0, 1'b0, 1'b1, c, 0);
    cycle(bgval(0, 8), 1'b1, 1'b0, 1'b0, 0, 0);
    vsync_edge(1'b0);
    chk("post_reset_no_done", 32'(o_frame_done), 0);
    vsync_tail();

    clear_fg();
    for (int c = 0; c <= 3; c++) fg[0][c] = 1'b1;
    run_frame(0, 1'b0);
    vsync_edge(1'b0);
    chk_box("postreset", 0, 3, 0, 0, 4, 1);
    vsync_tail();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/binary_bbox.md
BINARY_BBOX -- requirements
Module: binary_bbox

Interface
REQ-001 The block SHALL have these parameters:
  DW, 24, pixel data width.
  XW, 12, column counter width.
  YW, 12, row counter width.
  MIN_CNT, 64, minimum foreground pixel count for a valid box.
  BOX_COLOR, 24'hFF0000, overlay colour for box outline.
REQ-002 The block SHALL have these ports:
  pixelclk  in  1  pixel clock, all logic on rising edge.
  reset_n  in  1  asynchronous, active-low reset.
  i_binary  in  DW  binarized pixel; all-zero = foreground, any other value = background.
  i_hsync  in  1  line sync, passed through.
  i_vsync  in  1  frame sync, active-high; rising edge = frame boundary.
  i_de  in  1  active pixel strobe.
  o_data  out  DW  pixel after overlay.
  o_hsync  out  1  delayed i_hsync.
  o_vsync  out  1  delayed i_vsync.
  o_de  out  1  delayed i_de.
  o_x_min  out  XW  latched box left column.
  o_x_max  out  XW  latched box right column.
  o_y_min  out  YW  latched box top row.
  o_y_max  out  YW  latched box bottom row.
  o_fg_count  out  XW+YW  latched foreground pixel count of last frame.
  o_box_valid  out  1  latched box is valid.
  o_frame_done  out  1  one-cycle pulse when new results are latched.

Function
REQ-003 Position counters SHALL work as follows:
  x increments on every i_de=1 cycle and saturates at all-ones.
  x clears on the i_de falling edge; y increments on that same edge and saturates at all-ones.
  x and y both clear on the i_vsync rising edge, detected against the registered i_vsync.
REQ-004 The FSM SHALL have two states, IDLE and ACTIVE; reset enters IDLE.
  IDLE -> ACTIVE on the first i_vsync rising edge.
  No accumulation occurs in IDLE.
  That first edge produces no o_frame_done pulse.
REQ-005 In ACTIVE, each i_de=1 cycle with i_binary==0 SHALL update the accumulators:
  x_min=min(x_min,x), x_max=max(x_max,x), y_min=min(y_min,y), y_max=max(y_max,y).
  count increments and saturates at all-ones.
REQ-006 On each i_vsync rising edge in ACTIVE, the block SHALL latch results with the new values visible the next cycle:
  If count >= MIN_CNT: latch the four coordinates and count, and set o_box_valid=1.
  Otherwise: latch the coordinates as 0, latch the count, and set o_box_valid=0.
  Pulse o_frame_done high for exactly one cycle.
REQ-007 On the same edge, the accumulators SHALL reinitialise: x_min/y_min to all-ones, x_max/y_max to 0, count to 0.
  A foreground pixel coinciding with the edge cycle is discarded.
REQ-008 Latched outputs SHALL hold constant between frame_done pulses.
REQ-009 Pipeline latency from input to o_data/o_hsync/o_vsync/o_de SHALL be exactly 1 cycle, with all sync signals delayed identically.
REQ-010 Overlay: o_data SHALL equal BOX_COLOR when all of the following hold, else i_binary registered:
  o_box_valid=1 and i_de=1.
  Current (x,y) lies on the perimeter of the latched (previous-frame) box: (x==x_min or x==x_max) with y_min<=y<=y_max, or (y==y_min or y==y_max) with x_min<=x<=x_max.
REQ-011 All comparisons SHALL be unsigned; a single-pixel box (min==max) is legal and overlays that one pixel.

Reset
REQ-012 Asserting reset_n low SHALL immediately drive all outputs to 0, clear counters, reinitialise accumulators per REQ-007, and enter IDLE, including when asserted mid-frame.
REQ-013 After release, the first complete frame SHALL be accumulated only after the first i_vsync rising edge.

Verification
REQ-014 The bench SHALL cover these directed scenarios (8x4 active frame, MIN_CNT=4):
  Foreground at x 2..5, y 1..3 -> after the next vsync edge: box (2,5,1,3), o_fg_count=12, o_box_valid=1, o_frame_done high for 1 cycle.
  All-background frame -> o_box_valid=0, coordinates 0, o_fg_count=0.
  3 foreground pixels -> o_box_valid=0, o_fg_count=3.
  Frame following the valid box -> o_data=BOX_COLOR at (2,1), (5,3), (4,3); o_data=i_binary at (3,2); 1-cycle delay on o_hsync/o_vsync/o_de checked.
  Reset pulsed mid-frame -> all outputs 0 at once; the first vsync edge after release gives no o_frame_done; the following edge reports only post-reset pixels.
  Foreground pixel concurrent with the vsync rising edge -> excluded from both frames' results.
